tristate_bus_demux_rx: RTL and testbench

Receiving end of the shared single-bit tri-state bus. That bus is driven by the select/enable tri-state mux stage (inputs a/b, select s, output enable e). This block samples the bus bit on each clock while the driver is enabled and routes it by the same select line to one of two independent channel deserializers. It presents completed WIDTH-bit words per channel with a valid/ack handshake and sticky overrun flags. If the bus stays idle too long, partial words are discarded.

---
 rtl/tristate_bus_demux_rx.sv | 183 ++++++++++++++++++
 tb/tb_tristate_bus_demux_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_demux_rx.sv
// Receiver for the shared single-bit tri-state bus. Bits sampled while the
// driver is enabled are steered by the select line into one of two
// independent MSB-first deserializers. Each channel presents completed words
// with a valid/ack handshake and a sticky overrun flag. A run of idle cycles
// discards partial words and raises a one-cycle abort pulse.
module tristate_bus_demux_rx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             s,
  input  logic             e,
  input  logic             ack_a,
  input  logic             ack_b,
  output logic [WIDTH-1:0] wa,
  output logic             va,
  output logic             ova,
  output logic [WIDTH-1:0] wb,
  output logic             vb,
  output logic             ovb,
  output logic             abort
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  // Idle count value from which the next idle edge reaches the timeout.
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : {IW{1'b0}};
  localparam bit            TO_EN     = (TIMEOUT > 0);

  // Registered state
  logic [WIDTH-1:0] r_sr_a, r_sr_b;
  logic [CW-1:0]    r_cnt_a, r_cnt_b;
  logic [IW-1:0]    r_idle;
  logic [WIDTH-1:0] r_wa, r_wb;
  logic             r_va, r_vb, r_ova, r_ovb, r_abort;

  // Next-state values
  logic [WIDTH-1:0] w_sr_a_nxt, w_sr_b_nxt;
  logic [CW-1:0]    w_cnt_a_nxt, w_cnt_b_nxt;
  logic [IW-1:0]    w_idle_nxt;
  logic [WIDTH-1:0] w_wa_nxt, w_wb_nxt;
  logic             w_va_nxt, w_vb_nxt, w_ova_nxt, w_ovb_nxt, w_abort_nxt;

  logic             w_take_a, w_take_b, w_done_a, w_done_b, w_idle_hit;
  logic [WIDTH-1:0] w_word_a, w_word_b;

  assign w_take_a   = e & ~s;
  assign w_take_b   = e & s;
  assign w_done_a   = w_take_a & (r_cnt_a == LAST_BIT);
  assign w_done_b   = w_take_b & (r_cnt_b == LAST_BIT);
  assign w_word_a   = {r_sr_a[WIDTH-2:0], d};
  assign w_word_b   = {r_sr_b[WIDTH-2:0], d};
  // Timeout fires only on the idle edge that brings the counter to TIMEOUT.
  assign w_idle_hit = TO_EN & ~e & (r_idle == IDLE_LAST);

  // Next-state logic for both deserializers, the handshake and the idle timer
  always_comb begin
    w_sr_a_nxt  = r_sr_a;
    w_sr_b_nxt  = r_sr_b;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_idle_nxt  = r_idle;
    w_wa_nxt    = r_wa;
    w_wb_nxt    = r_wb;
    w_va_nxt    = r_va;
    w_vb_nxt    = r_vb;
    w_ova_nxt   = r_ova;
    w_ovb_nxt   = r_ovb;
    w_abort_nxt = 1'b0;

    // Idle counter: cleared by any enabled cycle, saturating otherwise.
    if (e) begin
      w_idle_nxt = {IW{1'b0}};
    end else if (r_idle != IDLE_MAX) begin
      w_idle_nxt = r_idle + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      w_idle_nxt = r_idle;
    end

    // Channel A shift path.
    if (w_idle_hit) begin
      w_sr_a_nxt  = {WIDTH{1'b0}};
      w_cnt_a_nxt = {CW{1'b0}};
    end else if (w_done_a) begin
      w_sr_a_nxt  = w_word_a;
      w_cnt_a_nxt = {CW{1'b0}};
    end else if (w_take_a) begin
      w_sr_a_nxt  = w_word_a;
      w_cnt_a_nxt = r_cnt_a + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_sr_a_nxt  = r_sr_a;
      w_cnt_a_nxt = r_cnt_a;
    end

    // Channel B shift path.
    if (w_idle_hit) begin
      w_sr_b_nxt  = {WIDTH{1'b0}};
      w_cnt_b_nxt = {CW{1'b0}};
    end else if (w_done_b) begin
      w_sr_b_nxt  = w_word_b;
      w_cnt_b_nxt = {CW{1'b0}};
    end else if (w_take_b) begin
      w_sr_b_nxt  = w_word_b;
      w_cnt_b_nxt = r_cnt_b + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_sr_b_nxt  = r_sr_b;
      w_cnt_b_nxt = r_cnt_b;
    end

    // Channel A output word; an ack on the completing edge consumes the old word.
    if (w_done_a) begin
      w_wa_nxt  = w_word_a;
      w_va_nxt  = 1'b1;
      w_ova_nxt = r_ova | (r_va & ~ack_a);
    end else if (r_va && ack_a) begin
      w_va_nxt  = 1'b0;
    end else begin
      w_va_nxt  = r_va;
    end

    // Channel B output word.
    if (w_done_b) begin
      w_wb_nxt  = w_word_b;
      w_vb_nxt  = 1'b1;
      w_ovb_nxt = r_ovb | (r_vb & ~ack_b);
    end else if (r_vb && ack_b) begin
      w_vb_nxt  = 1'b0;
    end else begin
      w_vb_nxt  = r_vb;
    end

    // Abort only reports when a partial word was actually thrown away.
    if (w_idle_hit && ((r_cnt_a != {CW{1'b0}}) || (r_cnt_b != {CW{1'b0}}))) begin
      w_abort_nxt = 1'b1;
    end else begin
      w_abort_nxt = 1'b0;
    end
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr_a  <= {WIDTH{1'b0}};
      r_sr_b  <= {WIDTH{1'b0}};
      r_cnt_a <= {CW{1'b0}};
      r_cnt_b <= {CW{1'b0}};
      r_idle  <= {IW{1'b0}};
      r_wa    <= {WIDTH{1'b0}};
      r_wb    <= {WIDTH{1'b0}};
      r_va    <= 1'b0;
      r_vb    <= 1'b0;
      r_ova   <= 1'b0;
      r_ovb   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_sr_a  <= w_sr_a_nxt;
      r_sr_b  <= w_sr_b_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_idle  <= w_idle_nxt;
      r_wa    <= w_wa_nxt;
      r_wb    <= w_wb_nxt;
      r_va    <= w_va_nxt;
      r_vb    <= w_vb_nxt;
      r_ova   <= w_ova_nxt;
      r_ovb   <= w_ovb_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign wa    = r_wa;
  assign va    = r_va;
  assign ova   = r_ova;
  assign wb    = r_wb;
  assign vb    = r_vb;
  assign ovb   = r_ovb;
  assign abort = r_abort;

endmodule

// File: tb/tb_tristate_bus_demux_rx.sv
// Directed bench for tristate_bus_demux_rx: expected words are queued when a
// word is driven and popped when the channel reports completion.
module tb_tristate_bus_demux_rx;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             d = 1'b0, s = 1'b0, e = 1'b0;
  logic             ack_a = 1'b0, ack_b = 1'b0;
  logic [WIDTH-1:0] wa, wb;
  logic             va, vb, ova, ovb, abort;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];

  tristate_bus_demux_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .d(d), .s(s), .e(e),
    .ack_a(ack_a), .ack_b(ack_b),
    .wa(wa), .va(va), .ova(ova),
    .wb(wb), .vb(vb), .ovb(ovb),
    .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic ch, input logic b, input logic ak);
    s = ch; d = b; e = 1'b1;
    if (ch) ack_b = ak; else ack_a = ak;
    step();
    e = 1'b0; d = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
  endtask

  task automatic idle(input int n);
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("abort_during_idle", {31'd0, abort}, (i == TIMEOUT - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic send_word(input logic ch, input logic [WIDTH-1:0] w, input logic ack_last);
    if (ch) q_b.push_back(w); else q_a.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(ch, w[i], (i == 0) ? ack_last : 1'b0);
  endtask

  task automatic pop_a();
    if (q_a.size() == 0) chk("qa_empty", 32'd1, 32'd0);
    else chk("wa", {24'd0, wa}, {24'd0, q_a.pop_front()});
    chk("va", {31'd0, va}, 32'd1);
  endtask

  task automatic pop_b();
    if (q_b.size() == 0) chk("qb_empty", 32'd1, 32'd0);
    else chk("wb", {24'd0, wb}, {24'd0, q_b.pop_front()});
    chk("vb", {31'd0, vb}, 32'd1);
  endtask

  task automatic pulse_ack(input logic ch);
    if (ch) ack_b = 1'b1; else ack_a = 1'b1;
    step();
    ack_a = 1'b0; ack_b = 1'b0;
  endtask

  logic [WIDTH-1:0] wv_a, wv_b;

  initial begin
    // Reset state
    do_reset();
    chk("rst_wa", {24'd0, wa}, 32'd0);
    chk("rst_va", {31'd0, va}, 32'd0);
    chk("rst_wb", {24'd0, wb}, 32'd0);
    chk("rst_vb", {31'd0, vb}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);

    // 1. Basic A; the bit before the last must not yet complete
    q_a.push_back(8'hA5);
    wv_a = 8'hA5;
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(1'b0, wv_a[i], 1'b0);
    chk("va_early", {31'd0, va}, 32'd0);
    send_bit(1'b0, wv_a[0], 1'b0);
    pop_a();
    chk("t1_vb", {31'd0, vb}, 32'd0);
    chk("t1_wb", {24'd0, wb}, 32'd0);
    chk("t1_abort", {31'd0, abort}, 32'd0);
    pulse_ack(1'b0);
    chk("t1_ack_va", {31'd0, va}, 32'd0);
    chk("t1_ack_wa_hold", {24'd0, wa}, 32'h0000_00A5);
    pulse_ack(1'b0);
    chk("t1_ack_idle_va", {31'd0, va}, 32'd0);

    // 2. Interleaved channels
    wv_a = 8'h3C; wv_b = 8'hC3;
    q_a.push_back(wv_a); q_b.push_back(wv_b);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(1'b0, wv_a[i], 1'b0);
      send_bit(1'b1, wv_b[i], 1'b0);
    end
    pop_a();
    pop_b();
    chk("t2_ova", {31'd0, ova}, 32'd0);
    chk("t2_ovb", {31'd0, ovb}, 32'd0);
    ack_a = 1'b1; ack_b = 1'b1;
    step();
    ack_a = 1'b0; ack_b = 1'b0;
    chk("t2_va_cleared", {31'd0, va}, 32'd0);
    chk("t2_vb_cleared", {31'd0, vb}, 32'd0);

    // 3. Overrun
    send_word(1'b0, 8'h11, 1'b0);
    pop_a();
    chk("t3_ova_first", {31'd0, ova}, 32'd0);
    send_word(1'b0, 8'h22, 1'b0);
    pop_a();
    chk("t3_ova_set", {31'd0, ova}, 32'd1);
    pulse_ack(1'b0);
    chk("t3_va_after_ack", {31'd0, va}, 32'd0);
    chk("t3_ova_sticky", {31'd0, ova}, 32'd1);
    chk("t3_ovb_clear", {31'd0, ovb}, 32'd0);

    // 4. Ack collides with completion
    do_reset();
    chk("t4_ova_rst", {31'd0, ova}, 32'd0);
    send_word(1'b0, 8'h11, 1'b0);
    pop_a();
    send_word(1'b0, 8'h77, 1'b1);
    pop_a();
    chk("t4_ova", {31'd0, ova}, 32'd0);
    pulse_ack(1'b0);

    // 5a. Short pause keeps the partial word
    wv_a = 8'hE7;
    q_a.push_back(wv_a);
    for (int i = WIDTH - 1; i >= WIDTH - 3; i--) send_bit(1'b0, wv_a[i], 1'b0);
    idle(TIMEOUT - 1);
    for (int i = WIDTH - 4; i >= 0; i--) send_bit(1'b0, wv_a[i], 1'b0);
    pop_a();
    chk("t5a_abort", {31'd0, abort}, 32'd0);
    pulse_ack(1'b0);

    // 5b. Timeout discards the partial word with a single abort pulse
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    idle(TIMEOUT + 2);
    chk("t5b_va_unaffected", {31'd0, va}, 32'd0);
    send_word(1'b0, 8'hFF, 1'b0);
    pop_a();
    chk("t5b_ova", {31'd0, ova}, 32'd0);
    pulse_ack(1'b0);
    // Long idle with nothing pending must not pulse abort
    e = 1'b0;
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      step();
      chk("no_abort_empty", {31'd0, abort}, 32'd0);
    end

    // 6. Reset mid-word on B
    wv_b = 8'h96;
    for (int i = WIDTH - 1; i >= WIDTH - 5; i--) send_bit(1'b1, wv_b[i], 1'b0);
    do_reset();
    chk("t6_wa", {24'd0, wa}, 32'd0);
    chk("t6_va", {31'd0, va}, 32'd0);
    chk("t6_ova", {31'd0, ova}, 32'd0);
    chk("t6_wb", {24'd0, wb}, 32'd0);
    chk("t6_vb", {31'd0, vb}, 32'd0);
    chk("t6_ovb", {31'd0, ovb}, 32'd0);
    chk("t6_abort", {31'd0, abort}, 32'd0);
    send_word(1'b1, 8'h5A, 1'b0);
    pop_b();
    chk("t6_ovb_after", {31'd0, ovb}, 32'd0);
    chk("t6_va_after", {31'd0, va}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
